// File: rtl/ppu_vga_out_if.sv
// PPU pixel-write / line-request side and VGA DAC pin side of ppu_vga_out.
interface ppu_vga_out_if;
    logic       pix_we;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic [5:0] pix_data;
    logic       line_req;
    logic [7:0] line_num;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;

    modport master (
        output pix_we, pix_x, pix_y, pix_data,
        input  line_req, line_num,
        input  VGA_R, VGA_G, VGA_B,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
    );

    modport slave (
        input  pix_we, pix_x, pix_y, pix_data,
        output line_req, line_num,
        output VGA_R, VGA_G, VGA_B,
        output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
    );
endinterface

// File: rtl/ppu_vga_out.sv
// PPU to VGA output stage: 2-bank scanline buffer, 2x scaling with side
// borders, 2C02 palette lookup and per-line render requests to the PPU.
module ppu_vga_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_BORDER = 64
) (
    input  logic          clk,
    input  logic          reset,
    ppu_vga_out_if.slave  io
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] PIC_BEG  = 10'(H_BORDER);
    localparam logic [9:0] PIC_END  = 10'(H_ACTIVE - H_BORDER);
    localparam logic [9:0] REQ_LAST = 10'(V_ACTIVE - 4);
    localparam logic [9:0] REQ_PRE  = 10'(V_TOTAL - 3);

    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic       r_fv;
    logic       r_line_req;
    logic [7:0] r_line_num;

    logic [5:0] r_bank0 [256];
    logic [5:0] r_bank1 [256];

    logic       r_hs1;
    logic       r_vs1;
    logic       r_act1;
    logic       r_pic1;
    logic [5:0] r_pix1;

    logic       r_hs2;
    logic       r_vs2;
    logic       r_bl2;
    logic [7:0] r_r;
    logic [7:0] r_g;
    logic [7:0] r_b;

    logic        w_h_last;
    logic        w_v_last;
    logic        w_active;
    logic        w_pic;
    logic        w_hs;
    logic        w_vs;
    logic        w_wr;
    logic        w_req;
    logic        w_pre;
    logic [7:0]  w_req_num;
    logic [9:0]  w_hoff;
    logic [7:0]  w_col;
    logic [23:0] w_rgb;

    function automatic logic [23:0] f_pal(input logic [5:0] idx);
        logic [23:0] c;
        case (idx)
            6'h00: c = 24'h666666;
            6'h01: c = 24'h002A88;
            6'h02: c = 24'h1412A7;
            6'h03: c = 24'h3B00A4;
            6'h04: c = 24'h5C007E;
            6'h05: c = 24'h6E0040;
            6'h06: c = 24'h6C0600;
            6'h07: c = 24'h561D00;
            6'h08: c = 24'h333500;
            6'h09: c = 24'h0B4800;
            6'h0A: c = 24'h005200;
            6'h0B: c = 24'h004F08;
            6'h0C: c = 24'h00404D;
            6'h10: c = 24'hADADAD;
            6'h11: c = 24'h155FD9;
            6'h12: c = 24'h4240FF;
            6'h13: c = 24'h7527FE;
            6'h14: c = 24'hA01ACC;
            6'h15: c = 24'hB71E7B;
            6'h16: c = 24'hB53120;
            6'h17: c = 24'h994E00;
            6'h18: c = 24'h6B6D00;
            6'h19: c = 24'h388700;
            6'h1A: c = 24'h0C9300;
            6'h1B: c = 24'h008F32;
            6'h1C: c = 24'h007C8D;
            6'h20: c = 24'hFFFEFF;
            6'h21: c = 24'h64B0FF;
            6'h22: c = 24'h9290FF;
            6'h23: c = 24'hC676FF;
            6'h24: c = 24'hF36AFF;
            6'h25: c = 24'hFE6ECC;
            6'h26: c = 24'hFE8170;
            6'h27: c = 24'hEA9E22;
            6'h28: c = 24'hBCBE00;
            6'h29: c = 24'h88D800;
            6'h2A: c = 24'h5CE430;
            6'h2B: c = 24'h45E082;
            6'h2C: c = 24'h48CDDE;
            6'h2D: c = 24'h4F4F4F;
            6'h30: c = 24'hFFFFFF;
            6'h31: c = 24'hC0DFFF;
            6'h32: c = 24'hD3D2FF;
            6'h33: c = 24'hE8C8FF;
            6'h34: c = 24'hFBC2FF;
            6'h35: c = 24'hFEC4EA;
            6'h36: c = 24'hFECCC5;
            6'h37: c = 24'hF7D8A5;
            6'h38: c = 24'hE4E594;
            6'h39: c = 24'hCFEF96;
            6'h3A: c = 24'hBDF4AB;
            6'h3B: c = 24'hB3F3CC;
            6'h3C: c = 24'hB5EBF2;
            6'h3D: c = 24'hB8B8B8;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    assign w_h_last = (r_hcnt == H_LAST);
    assign w_v_last = (r_vcnt == V_LAST);
    assign w_active = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    assign w_pic    = w_active && (r_hcnt >= PIC_BEG) && (r_hcnt < PIC_END);
    assign w_hs     = !((r_hcnt >= HS_BEG) && (r_hcnt < HS_END));
    assign w_vs     = !((r_vcnt >= VS_BEG) && (r_vcnt < VS_END));
    assign w_hoff   = r_hcnt - PIC_BEG;
    assign w_col    = 8'(w_hoff >> 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            r_hcnt <= w_h_last ? '0 : r_hcnt + 10'd1;
            if (w_h_last) begin
                r_vcnt <= w_v_last ? '0 : r_vcnt + 10'd1;
            end
        end
    end

    // Line n lands in bank n[0]; pix_y >= 240 is off-screen and dropped.
    assign w_wr = io.pix_we && (io.pix_y < 8'd240);

    always_ff @(posedge clk) begin
        if (w_wr && !io.pix_y[0]) begin
            r_bank0[io.pix_x] <= io.pix_data;
        end
        if (w_wr && io.pix_y[0]) begin
            r_bank1[io.pix_x] <= io.pix_data;
        end
    end

    // Request line k+1 at the start of the first VGA line showing line k.
    assign w_pre     = (r_vcnt == REQ_PRE);
    assign w_req     = (r_hcnt == '0)
                     && ((!r_vcnt[0] && (r_vcnt <= REQ_LAST)) || w_pre);
    assign w_req_num = w_pre ? 8'd0 : 8'((r_vcnt >> 1) + 10'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line_req <= 1'b0;
            r_line_num <= '0;
            r_fv       <= 1'b0;
        end else begin
            r_line_req <= w_req;
            if (w_req) begin
                r_line_num <= w_req_num;
            end
            if ((r_hcnt == '0) && w_pre) begin
                r_fv <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
            r_act1 <= 1'b0;
            r_pic1 <= 1'b0;
            r_pix1 <= '0;
        end else begin
            r_hs1  <= w_hs;
            r_vs1  <= w_vs;
            r_act1 <= w_active;
            r_pic1 <= w_pic;
            r_pix1 <= r_vcnt[1] ? r_bank1[w_col] : r_bank0[w_col];
        end
    end

    // Nothing is shown until the first full line 0..239 pass has been requested.
    assign w_rgb = (r_pic1 && r_fv) ? f_pal(r_pix1) : 24'h000000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hs2 <= 1'b1;
            r_vs2 <= 1'b1;
            r_bl2 <= 1'b0;
            r_r   <= '0;
            r_g   <= '0;
            r_b   <= '0;
        end else begin
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            r_bl2 <= r_act1;
            r_r   <= w_rgb[23:16];
            r_g   <= w_rgb[15:8];
            r_b   <= w_rgb[7:0];
        end
    end

    assign io.line_req    = r_line_req;
    assign io.line_num    = r_line_num;
    assign io.VGA_R       = r_r;
    assign io.VGA_G       = r_g;
    assign io.VGA_B       = r_b;
    assign io.VGA_HS      = r_hs2;
    assign io.VGA_VS      = r_vs2;
    assign io.VGA_BLANK_N = r_bl2;
    assign io.VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_ppu_vga_out.sv
// Scoreboard bench for ppu_vga_out with a short vertical frame (22 lines)
// so several frames fit in the cycle budget; horizontal timing is full size.
module tb_ppu_vga_out;

    localparam int VA   = 16;
    localparam int VFP  = 2;
    localparam int VSY  = 2;
    localparam int VBP  = 2;
    localparam int VT   = VA + VFP + VSY + VBP;
    localparam int HT   = 800;
    localparam int VPRE = VT - 3;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bl;
        logic [23:0] rgb;
    } pix_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ppu_vga_out_if bus ();

    ppu_vga_out #(
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VSY),
        .V_BP     (VBP)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    pix_t q[$];
    int   mh;
    int   mv;
    bit   mfv;
    logic [5:0] sh [2][256];
    event tick;

    function automatic logic [23:0] pal(input logic [5:0] i);
        case (i)
            6'h0F: return 24'h000000;
            6'h30: return 24'hFFFFFF;
            6'h16: return 24'hB53120;
            6'h21: return 24'h64B0FF;
            default: return 24'hDEAD00;
        endcase
    endfunction

    function automatic pix_t expect_at(input int h, input int v);
        pix_t e;
        bit act;
        act   = (h < 640) && (v < VA);
        e.hs  = !((h >= 656) && (h < 752));
        e.vs  = !((v >= VA + VFP) && (v < VA + VFP + VSY));
        e.bl  = act;
        e.rgb = 24'h0;
        if (act && mfv && (h >= 64) && (h < 576)) begin
            e.rgb = pal(sh[(v >> 1) & 1][(h - 64) >> 1]);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            if (errors <= 20) begin
                $display("FAIL %s: got %h expected %h (t=%0t h=%0d v=%0d)",
                         nm, a, e, $time, mh, mv);
            end
        end
    endtask

    // Monitor: advance the position model, queue its expectation and
    // compare the pins against the entry from two clocks earlier.
    initial begin
        pix_t e;
        bit   er;
        int   en;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mh++;
                if (mh == HT) begin
                    mh = 0;
                    mv++;
                    if (mv == VT) mv = 0;
                end
                if (mh == 0 && mv == VPRE) mfv = 1'b1;
                q.push_back(expect_at(mh, mv));
                e = q.pop_front();
                chk("pins",
                    32'({bus.VGA_SYNC_N, bus.VGA_HS, bus.VGA_VS,
                         bus.VGA_BLANK_N, bus.VGA_R, bus.VGA_G, bus.VGA_B}),
                    32'({1'b0, e.hs, e.vs, e.bl, e.rgb}));
                er = (mh == 1) && (((mv % 2) == 0 && mv <= VA - 4)
                                   || mv == VPRE);
                en = (mv == VPRE) ? 0 : mv / 2 + 1;
                chk("line_req", 32'(bus.line_req), 32'(er));
                if (er) chk("line_num", 32'(bus.line_num), 32'(en));
                ->tick;
            end
        end
    end

    task automatic release_rst();
        pix_t r;
        r = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, rgb: 24'h0};
        q.delete();
        mh  = 0;
        mv  = 0;
        mfv = 1'b0;
        q.push_back(r);
        q.push_back(expect_at(0, 0));
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_pins(input string tag);
        chk({tag, "_hs"},    32'(bus.VGA_HS), 32'd1);
        chk({tag, "_vs"},    32'(bus.VGA_VS), 32'd1);
        chk({tag, "_blank"}, 32'(bus.VGA_BLANK_N), 32'd0);
        chk({tag, "_rgb"},   32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'd0);
        chk({tag, "_sync"},  32'(bus.VGA_SYNC_N), 32'd0);
        chk({tag, "_req"},   32'(bus.line_req), 32'd0);
        chk({tag, "_num"},   32'(bus.line_num), 32'd0);
    endtask

    task automatic wr(input int x, input int y, input logic [5:0] d);
        @(tick);
        bus.pix_we   = 1'b1;
        bus.pix_x    = 8'(x);
        bus.pix_y    = 8'(y);
        bus.pix_data = d;
        if (y < 240) sh[y & 1][x] = d;
    endtask

    task automatic idle();
        @(tick);
        bus.pix_we = 1'b0;
    endtask

    task automatic wait_pos(input int h, input int v, input int lim);
        bit found = 1'b0;
        for (int n = 0; n < lim && !found; n++) begin
            @(tick);
            if (mh == h && mv == v) found = 1'b1;
        end
        chk("wait_pos", 32'(found), 32'd1);
    endtask

    task automatic wait_req(input bit any, input int num, input int lim,
                            output int got, output int at_v);
        bit found = 1'b0;
        got  = -1;
        at_v = -1;
        for (int n = 0; n < lim && !found; n++) begin
            @(tick);
            if (bus.line_req && (any || (mfv && bus.line_num == 8'(num)))) begin
                found = 1'b1;
                got   = int'(bus.line_num);
                at_v  = mv;
            end
        end
        chk("wait_req", 32'(found), 32'd1);
    endtask

    // One frame's worth of consecutive clocks from any starting point.
    task automatic window();
        int hsl = 0, hsf = 0, vsl = 0, bln = 0, req = 0, sum = 0;
        logic hs_d = 1'b1;
        repeat (HT * VT) begin
            @(tick);
            if (!bus.VGA_HS) hsl++;
            if (hs_d && !bus.VGA_HS) hsf++;
            hs_d = bus.VGA_HS;
            if (!bus.VGA_VS) vsl++;
            if (bus.VGA_BLANK_N) bln++;
            if (bus.line_req) begin
                req++;
                sum += int'(bus.line_num);
            end
        end
        chk("hs_low_clks",  32'(hsl), 32'(VT * 96));
        chk("hs_periods",   32'(hsf), 32'(VT));
        chk("vs_low_clks",  32'(vsl), 32'(VSY * HT));
        chk("blank_n_high", 32'(bln), 32'(640 * VA));
        chk("req_count",    32'(req), 32'(VA / 2));
        chk("req_num_sum",  32'(sum), 32'(28));
    endtask

    initial begin
        int got;
        int at_v;
        bus.pix_we   = 1'b0;
        bus.pix_x    = '0;
        bus.pix_y    = '0;
        bus.pix_data = '0;
        mh  = 0;
        mv  = 0;
        mfv = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_pins("por");
        release_rst();

        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 256; x++) wr(x, y, 6'h30);
        end
        idle();

        fork
            window();
            begin
                wait_req(1'b0, 5, 40000, got, at_v);
                chk("req5_vcnt", 32'(at_v), 32'd8);
                for (int x = 0; x < 256; x++) begin
                    wr(x, 5, (x == 10) ? 6'h30 : 6'h16);
                end
                for (int x = 0; x < 8; x++) wr(x, 240, 6'h21);
                wr(3, 255, 6'h21);
                idle();
            end
        join

        wait_pos(400, 12, 40000);
        #1;
        chk("pre_rst_num", 32'(bus.line_num), 32'd7);
        rst_n = 1'b0;
        #1;
        chk_reset_pins("mid");
        repeat (5) @(negedge clk);
        #1;
        chk_reset_pins("held");
        release_rst();

        wait_req(1'b1, 0, 2000, got, at_v);
        chk("first_req_num",  32'(got), 32'd1);
        chk("first_req_vcnt", 32'(at_v), 32'd0);
        wait_pos(0, 4, 5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppu_vga_out.md
Name: ppu_vga_out

Overview:
- Downstream output stage of the PPU: takes the PPU's 256x240 pixel stream of 6-bit palette indices and drives the 640x480@60 VGA DAC pins.
- Double-buffers one NES scanline per bank, scales 2x in both axes and centres the picture horizontally with 64-pixel black borders.
- Converts palette indices to 8-bit RGB through the team's standard 2C02 palette ROM.
- Paces the PPU by issuing per-line render requests.

Parameters:
- H_ACTIVE, 640, visible VGA pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, HS pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible VGA lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VS pulse width
- V_BP, 33, vertical back porch
- H_BORDER, 64, black border width on left and right

Ports:
- clk  in  1  25 MHz pixel clock
- reset  in  1  asynchronous reset, active-low (asserted at 0)
- pix_we  in  1  PPU pixel write strobe
- pix_x  in  8  NES pixel column 0..255
- pix_y  in  8  NES scanline 0..239; selects bank pix_y[0]
- pix_data  in  6  palette index
- line_req  out  1  one-clock pulse: render NES line line_num now
- line_num  out  8  NES line requested
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
- VGA_HS, VGA_VS  out  1 each  syncs, active-low
- VGA_BLANK_N  out  1  0 outside the active area
- VGA_SYNC_N  out  1  tied 0

Behaviour:
- Timing counters:
  - hcnt 0..799 and vcnt 0..524 free-run.
  - hcnt wraps 799->0; vcnt increments on each hcnt wrap and wraps 524->0.
  - Active area: hcnt<640 and vcnt<480.
  - HS low for hcnt 656..751; VS low for vcnt 490..491.
- Line buffer:
  - Two banks of 256x6, with no reset on contents.
  - Write occurs when pix_we=1 and pix_y<240: bank[pix_y[0]][pix_x] <= pix_data.
  - Writes with pix_y>=240 are ignored.
- Read mapping:
  - NES line n = vcnt>>1; bank n[0].
  - NES column = (hcnt-64)>>1 for 64<=hcnt<576.
  - hcnt<64 or hcnt>=576 inside the active area gives black.
- Request schedule (at hcnt==0):
  - vcnt even and vcnt<=476: line_num=(vcnt>>1)+1.
  - vcnt==522: line_num=0.
  - Line k is therefore written into bank k[0] while line k-1 is displayed from the other bank, so reads and writes never hit the same bank when the PPU honours requests.
  - A write to the displayed bank is not blocked; the last written value wins.
- Pipeline, total 2-clock latency from counter position to pins:
  - Stage 1: registered RAM read; HS, VS and active flags delayed 1 clock.
  - Stage 2: registered palette ROM lookup; HS, VS and BLANK_N delayed again.
  - When blanked, RGB=0.
- frame_valid flag:
  - Cleared by reset; set at the first vcnt==522 (hcnt==0).
  - While clear, active pixels output RGB=0 (BLANK_N still toggles normally).
  - Once set, it stays set until reset.
- Palette spot values (R,G,B):
  - 0x0F = 00,00,00
  - 0x30 = FF,FF,FF
  - 0x16 = B5,31,20
  - 0x21 = 64,B0,FF
- Reset values:
  - hcnt=vcnt=0, all pipeline registers cleared.
  - line_req=0, line_num=0.
  - VGA_HS=VGA_VS=1, VGA_BLANK_N=0, RGB=0, VGA_SYNC_N=0.
- Reset mid-frame: counters, pipeline and frame_valid return to reset values immediately (async); the first line_req after release comes at vcnt=0 (line_num=1).

Test Plan:
- Release reset, run 2 frames -> HS period 800 clocks with 96-clock low pulse starting 2 clocks after hcnt=656; VS period 420000 clocks with low for 2 lines; BLANK_N high for exactly 640x480 per frame.
- Count line_req over one frame -> exactly 240 pulses; sequence 0 (at vcnt 522), 1 (vcnt 0), 2 (vcnt 2), ... 239 (vcnt 476).
- After frame_valid is set, write line 5 with all pix_data=0x16 and column 10=0x30 -> VGA lines 10 and 11 show B5,31,20 at hcnt 64..575, except hcnt 84..85 = FF,FF,FF; borders 0.
- First frame after reset with banks preloaded to 0x30 -> all RGB=0 until vcnt 522; the next frame shows white.
- Write with pix_y=240, value 0x21 -> no bank change; displayed data is unchanged.
- Assert reset at vcnt=300, hcnt=400 -> outputs go to reset values in the same cycle; after release HS/VS restart from hcnt=vcnt=0 and the first line_req has line_num=1.
